seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, pattern length and
// overlap mode. Each accepted bit is shifted into a history register. A match
// produces a registered one-cycle pulse on flag and bumps a saturating match
// counter.
module seq_detect_param #(
    parameter int                 MAX_LEN         = 16,
    parameter int                 CNT_W           = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 'h0055,
    parameter int                 DEFAULT_LEN     = 8,
    parameter bit                 DEFAULT_OVERLAP = 1'b1,
    localparam int                LW              = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               flag,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    // Active configuration, changed only by reset or cfg_load.
    logic [MAX_LEN-1:0] pattern_r;
    logic [LW-1:0]      len_r;
    logic               overlap_r;

    // Bit history, with the newest bit at [0], and the count of valid bits
    // seen since the last clear. The count saturates at len_r.
    logic [MAX_LEN-1:0] history_r;
    logic [LW-1:0]      fill_r;

    logic [MAX_LEN-1:0] hist_upd;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW:0]        fill_inc;
    logic               hit;

    // Force a requested length into the legal range 1..MAX_LEN.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0)
            return LW'(1);
        else if (l > LW'(MAX_LEN))
            return LW'(MAX_LEN);
        else
            return l;
    endfunction

    // Increment the count, holding it once it reaches all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c)
            return c;
        else
            return c + CNT_W'(1);
    endfunction

    // Build the compare mask: only the low len_r bits take part in a match.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_r));
        end
    end

    // Look ahead at the history and fill count as they would be after
    // accepting din. Data offered alongside cfg_load is never looked at.
    always_comb begin
        hist_upd = {history_r[MAX_LEN-2:0], din};
        fill_inc = {1'b0, fill_r} + (LW+1)'(1);
        hit      = din_valid && !cfg_load &&
                   (fill_inc >= {1'b0, len_r}) &&
                   ((hist_upd & len_mask) == (pattern_r & len_mask));
    end

    // State update. Priority is reset, then configuration load, then data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_r <= DEFAULT_PATTERN;
            len_r     <= clamp_len(LW'(DEFAULT_LEN));
            overlap_r <= DEFAULT_OVERLAP;
            history_r <= '0;
            fill_r    <= '0;
            match_cnt <= '0;
            flag      <= 1'b0;
        end else if (cfg_load) begin
            pattern_r <= cfg_pattern;
            len_r     <= clamp_len(cfg_len);
            overlap_r <= cfg_overlap;
            history_r <= '0;
            fill_r    <= '0;
            match_cnt <= '0;
            flag      <= 1'b0;
        end else begin
            flag <= hit;
            if (din_valid) begin
                history_r <= hist_upd;
                // In non-overlap mode a match starts the next one from
                // scratch. In overlap mode the fill count is untouched, so
                // the tail of this match can begin the next one.
                if (hit && !overlap_r)
                    fill_r <= '0;
                else if (fill_r < len_r)
                    fill_r <= fill_r + LW'(1);
            end
            if (hit)
                match_cnt <= sat_inc(match_cnt);
        end
    end

    assign cnt_sat = &match_cnt;

endmodule
